// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Bundles the MEM-stage data-memory request/response signals shared by the
// pipeline (master) and the data memory responder (slave).
//
// Signals:
//   MemRead   pipeline -> memory  load request
//   MemWrite  pipeline -> memory  store request
//   Address   pipeline -> memory  32-bit byte address
//   WriteData pipeline -> memory  32-bit store data
//   ByteSel   pipeline -> memory  byte-lane enables (only honoured when the
//                                 responder is built with DMEM_BYTE_EN)
//   ReadData  memory -> pipeline  load data, valid while MemDone is high
//   MemStall  memory -> pipeline  pipeline hold request
//   MemDone   memory -> pipeline  one-cycle completion pulse
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [3:0]  ByteSel;
    logic [31:0] ReadData;
    logic        MemStall;
    logic        MemDone;

    modport master (
        output MemRead,
        output MemWrite,
        output Address,
        output WriteData,
        output ByteSel,
        input  ReadData,
        input  MemStall,
        input  MemDone
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  Address,
        input  WriteData,
        input  ByteSel,
        output ReadData,
        output MemStall,
        output MemDone
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data memory for a pipelined CPU. A load or store seen in IDLE
// is latched, held for LATENCY wait cycles, then completed with a one-cycle
// MemDone pulse. MemStall freezes the pipeline while an access is pending.
//
// Parameters:
//   LATENCY  wait cycles per access, 1..15
//   DEPTH    number of 32-bit words, power of two, at least 2
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset; clears FSM, outputs and storage
//   bus      dmem_responder_if.slave (MemRead, MemWrite, Address, WriteData,
//            ByteSel in; ReadData, MemStall, MemDone out)
//
// Build option:
//   DMEM_BYTE_EN  when defined, stores update only lanes with ByteSel[i]=1;
//                 when undefined, ByteSel is ignored and stores write the
//                 full word.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [3:0]     cnt;

    logic [AW-1:0]  lat_idx;
    logic [31:0]    lat_wdata;
    logic           lat_read;
    logic           lat_write;
`ifdef DMEM_BYTE_EN
    logic [3:0]     lat_bsel;
`endif

    logic [31:0]    mem [DEPTH];
    logic [31:0]    read_data;

    logic           req;
    logic           commit;
    logic [31:0]    cur_word;
    logic [31:0]    store_word;
    logic           unused_bits;

    assign req      = bus.MemRead | bus.MemWrite;
    // The last wait cycle: storage and ReadData update on the edge that ends it.
    assign commit   = (state == ST_WAIT) && (cnt == 4'd0);
    assign cur_word = mem[lat_idx];

    // Word that a store leaves in storage, merging lanes when byte enables exist.
`ifdef DMEM_BYTE_EN
    always_comb begin
        store_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (lat_bsel[i]) begin
                store_word[8*i +: 8] = lat_wdata[8*i +: 8];
            end
        end
    end

    assign unused_bits = ^{bus.Address[31:AW+2], bus.Address[1:0]};
`else
    always_comb begin
        store_word = lat_wdata;
    end

    assign unused_bits = ^{bus.Address[31:AW+2], bus.Address[1:0], bus.ByteSel};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE always falls back to IDLE so a request held
    // through DONE is only accepted one cycle later.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request capture, wait counter, storage and the ReadData register.
    // Inputs are only looked at in IDLE, so anything the pipeline does to
    // them during WAIT cannot disturb the latched access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
`ifdef DMEM_BYTE_EN
            lat_bsel  <= 4'd0;
`endif
            read_data <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            if ((state == ST_IDLE) && req) begin
                cnt       <= CNT_LOAD;
                lat_idx   <= bus.Address[AW+1:2];
                lat_wdata <= bus.WriteData;
                lat_read  <= bus.MemRead;
                lat_write <= bus.MemWrite;
`ifdef DMEM_BYTE_EN
                lat_bsel  <= bus.ByteSel;
`endif
            end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                if (lat_write) begin
                    mem[lat_idx] <= store_word;
                end
                // A load (alone or combined with a store) returns the
                // pre-write word; a plain store reflects what was stored.
                if (lat_read) begin
                    read_data <= cur_word;
                end else begin
                    read_data <= store_word;
                end
            end
        end
    end

    assign bus.ReadData = read_data;
    assign bus.MemDone  = (state == ST_DONE);
    // Combinational stall, forced low while reset is asserted.
    assign bus.MemStall = rst_n && ((state == ST_WAIT) || ((state == ST_IDLE) && req));

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Scoreboard bench for dmem_responder (LATENCY=2, DEPTH=64). Each issued
// access pushes its hand-computed ReadData into a queue; a monitor pops and
// compares whenever MemDone is seen. Timing, reset and hold behaviour are
// checked directly by the stimulus process.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT = 2;

`ifdef DMEM_BYTE_EN
    localparam logic [31:0] EXP_BYTE  = 32'h00BB00DD;
    localparam logic [31:0] EXP_ZERO  = 32'h00BB00DD;
`else
    localparam logic [31:0] EXP_BYTE  = 32'hAABBCCDD;
    localparam logic [31:0] EXP_ZERO  = 32'hFFFFFFFF;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dmem_responder_if bus ();

    dmem_responder #(
        .LATENCY (LAT),
        .DEPTH   (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && bus.MemDone) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got MemDone=1, expected no pending access");
            end else begin
                e = exp_q.pop_front();
                checkOutput("read_data", bus.ReadData, e);
            end
        end
    end

    // One access: request held for a single cycle, then inputs scrambled
    // while the responder waits. Returns stall-high cycles and the cycle
    // index (request cycle = 0) of the MemDone pulse.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] bsel,
                                 input logic [31:0] exp_rd,
                                 output int stall_cnt, output int done_cyc);
        @(posedge clk);
        #1;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.Address   = addr;
        bus.WriteData = wdata;
        bus.ByteSel   = bsel;
        exp_q.push_back(exp_rd);
        stall_cnt = 0;
        done_cyc  = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.MemStall) stall_cnt++;
            if (bus.MemDone) begin
                done_cyc = c;
                break;
            end
            if (c == 0) begin
                @(posedge clk);
                #1;
                bus.MemRead   = 1'b0;
                bus.MemWrite  = 1'b0;
                bus.Address   = ~addr;
                bus.WriteData = ~wdata;
                bus.ByteSel   = ~bsel;
            end
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no MemDone in 40 cycles, expected 0x%08h", exp_rd);
            if (exp_q.size() != 0) void'(exp_q.pop_back());
        end else begin
            @(negedge clk);
            checkOutput("done_pulse_width", 32'(bus.MemDone), 32'd0);
            checkOutput("read_data_hold", bus.ReadData, exp_rd);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        int dc;
        int pulses;
        int last;

        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.Address   = 32'd0;
        bus.WriteData = 32'd0;
        bus.ByteSel   = 4'hF;

        // Reset state, with a request pending that must not raise MemStall.
        #12;
        checkOutput("reset_read_data", bus.ReadData, 32'd0);
        checkOutput("reset_done", 32'(bus.MemDone), 32'd0);
        checkOutput("reset_stall", 32'(bus.MemStall), 32'd0);
        bus.MemRead = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Store then load, with timing checks on the store.
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, st, dc);
        checkOutput("store_stall_cycles", 32'(st), 32'(LAT + 1));
        checkOutput("store_done_cycle", 32'(dc), 32'(LAT + 1));
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, st, dc);
        checkOutput("load_stall_cycles", 32'(st), 32'(LAT + 1));

        // Out-of-range address wraps onto word 4.
        applyStimulus(1'b1, 1'b0, 32'h110, 32'h0, 4'hF, 32'hDEADBEEF, st, dc);

        // Combined read+write returns the old word, then the new one.
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h11111111, st, dc);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h22222222, 4'hF, 32'h11111111, st, dc);
        applyStimulus(1'b1, 1'b0, 32'h23, 32'h0, 4'hF, 32'h22222222, st, dc);

        // Byte lanes.
        applyStimulus(1'b0, 1'b1, 32'h30, 32'h00000000, 4'hF, 32'h00000000, st, dc);
        applyStimulus(1'b0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, EXP_BYTE, st, dc);
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, EXP_BYTE, st, dc);

        // Back-to-back loads with MemRead held high.
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h22222222);
        exp_q.push_back(EXP_BYTE);
        @(posedge clk);
        #1;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        bus.Address  = 32'h10;
        pulses = 0;
        last   = -1;
        for (int cyc = 0; cyc < 60 && pulses < 3; cyc++) begin
            @(negedge clk);
            if (bus.MemDone) begin
                if (last >= 0) checkOutput("b2b_gap", 32'(cyc - last), 32'(LAT + 2));
                last = cyc;
                pulses++;
                case (pulses)
                    1: bus.Address = 32'h20;
                    2: bus.Address = 32'h30;
                    default: bus.MemRead = 1'b0;
                endcase
            end
        end
        bus.MemRead = 1'b0;
        checkOutput("b2b_pulses", 32'(pulses), 32'd3);
        repeat (8) @(negedge clk);

        // All-zero byte enables.
        applyStimulus(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, EXP_ZERO, st, dc);
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, EXP_ZERO, st, dc);

        // Reset during WAIT aborts the store and clears storage.
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b1;
        bus.Address   = 32'h40;
        bus.WriteData = 32'h12345678;
        bus.ByteSel   = 4'hF;
        @(posedge clk);
        #1 bus.MemWrite = 1'b0;
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.MemRead = 1'b1;
        #1;
        checkOutput("abort_read_data", bus.ReadData, 32'd0);
        checkOutput("abort_done", 32'(bus.MemDone), 32'd0);
        checkOutput("abort_stall", 32'(bus.MemStall), 32'd0);
        bus.MemRead = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h00000000, st, dc);
        checkOutput("post_reset_stall_cycles", 32'(st), 32'(LAT + 1));
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h00000000, st, dc);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
